sr_latch_driver: RTL and testbench

Upstream stage for the SR latch. Takes two raw, bouncy, asynchronous push-button inputs (set and clear) and turns them into clean, clock-synchronous `S`/`R` pulses for the latch's `S`/`R` inputs. The block guarantees that the latch never sees the invalid `S=R=1` combination. It synchronizes, debounces and edge-detects each input, then arbitrates the two channels and sequences pulse emission through a small FSM.

---
 rtl/sr_latch_driver_if.sv | 29 ++
 rtl/sr_latch_driver.sv | 148 ++++++++++++++
 tb/tb_sr_latch_driver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_if.sv
// Bundles the button inputs and latch-side outputs of sr_latch_driver.
// Ports: set_raw/clr_raw (raw buttons), S/R (latch pulses), busy, conflict.
// master = stimulus/button side, slave = the driver block itself.
interface sr_latch_driver_if;
    logic set_raw;
    logic clr_raw;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    modport master (
        output set_raw,
        output clr_raw,
        input  S,
        input  R,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_raw,
        input  clr_raw,
        output S,
        output R,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Purpose: turns two bouncy async buttons into clean, never-overlapping S/R latch pulses.
// Latency: S/R rise DEBOUNCE_CYCLES+2 edges after a stable press is first sampled.
// Backpressure: none; requests during a pulse are held in a one-deep pending bit per channel.
//
// Ports: clk, rst (sync, active-high); bus.set_raw / bus.clr_raw in;
//        bus.S / bus.R pulses, bus.busy (FSM not idle), bus.conflict (simultaneous press) out.
module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PUL_W = $clog2(PULSE_LEN + 1);

    // Channel index 0 = set, 1 = clear.
    localparam int CH_SET = 0;
    localparam int CH_CLR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer + debouncer + rising-edge detect, per channel
    // ------------------------------------------------------------------
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_prev_q;
    logic [DEB_W-1:0] cnt_q [2];
    logic [DEB_W-1:0] cnt_d [2];
    logic [1:0]       req;

    assign raw = {bus.clr_raw, bus.set_raw};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            deb_d[c] = deb_q[c];
            cnt_d[c] = '0;
            if (sync2_q[c] != deb_q[c]) begin
                // Flip on the cycle the count would reach DEBOUNCE_CYCLES.
                if (cnt_q[c] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[c] = ~deb_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + DEB_W'(1);
                end
            end
        end
    end

    // Press only; release edges are ignored.
    assign req = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Pulse sequencer
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [PUL_W-1:0] pcnt_q, pcnt_d;
    logic             pend_set_q, pend_set_d;
    logic             pend_clr_q, pend_clr_d;
    logic             conflict_q, conflict_d;
    logic             want_set, want_clr;

    // State register (also carries the synchronizer/debouncer flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            conflict_q <= conflict_d;
        end
    end

    assign want_set = pend_set_q | req[CH_SET];
    assign want_clr = pend_clr_q | req[CH_CLR];

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        pend_set_d = want_set;
        pend_clr_d = want_clr;
        conflict_d = 1'b0;
        case (state_q)
            // GAP arbitrates like IDLE so a pending pulse follows after
            // exactly one low cycle with busy held high.
            IDLE, GAP: begin
                if (state_q == IDLE) begin
                    conflict_d = req[CH_SET] & req[CH_CLR];
                end
                state_d = IDLE;
                if (want_clr) begin
                    // Clear wins; a concurrent set stays pending.
                    state_d    = CLR_P;
                    pcnt_d     = '0;
                    pend_clr_d = 1'b0;
                end else if (want_set) begin
                    state_d    = SET_P;
                    pcnt_d     = '0;
                    pend_set_d = 1'b0;
                end
            end
            SET_P, CLR_P: begin
                if (pcnt_q == PUL_W'(PULSE_LEN - 1)) begin
                    state_d = GAP;
                end else begin
                    pcnt_d = pcnt_q + PUL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from a single state, so S and R can never overlap.
    always_comb begin
        bus.S        = (state_q == SET_P);
        bus.R        = (state_q == CLR_P);
        bus.busy     = (state_q != IDLE);
        bus.conflict = conflict_q;
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

    logic clk;
    logic rst;

    sr_latch_driver_if ifa ();
    sr_latch_driver_if ifb ();
    sr_latch_driver_if ifc ();

    // a: defaults; b: PULSE_LEN=3; c: PULSE_LEN=4
    sr_latch_driver dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sr_latch_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    sr_latch_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;
        bit rst;
        bit set;
        bit clr;
        bit s;
        bit r;
        bit busy;
        bit conf;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add_n(input int n, input int sel, input bit rst_v, input bit set_v,
                         input bit clr_v, input bit s_v, input bit r_v, input bit b_v,
                         input bit c_v);
        vec_t v;
        v = '{sel, rst_v, set_v, clr_v, s_v, r_v, b_v, c_v};
        repeat (n) tbl.push_back(v);
    endtask

    // Drive one cycle of inputs to the selected DUT (others idle), then
    // step past the rising edge so outputs reflect that edge.
    task automatic drive(input int sel, input bit rst_v, input bit set_v, input bit clr_v);
        rst = rst_v;
        ifa.set_raw = 1'b0; ifa.clr_raw = 1'b0;
        ifb.set_raw = 1'b0; ifb.clr_raw = 1'b0;
        ifc.set_raw = 1'b0; ifc.clr_raw = 1'b0;
        case (sel)
            0:       begin ifa.set_raw = set_v; ifa.clr_raw = clr_v; end
            1:       begin ifb.set_raw = set_v; ifb.clr_raw = clr_v; end
            default: begin ifc.set_raw = set_v; ifc.clr_raw = clr_v; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic act, input bit exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input int sel, input bit s_e, input bit r_e,
                         input bit b_e, input bit c_e);
        logic s_a, r_a, b_a, c_a;
        case (sel)
            0:       begin s_a = ifa.S; r_a = ifa.R; b_a = ifa.busy; c_a = ifa.conflict; end
            1:       begin s_a = ifb.S; r_a = ifb.R; b_a = ifb.busy; c_a = ifb.conflict; end
            default: begin s_a = ifc.S; r_a = ifc.R; b_a = ifc.busy; c_a = ifc.conflict; end
        endcase
        cmp({tag, " S"}, s_a, s_e);
        cmp({tag, " R"}, r_a, r_e);
        cmp({tag, " busy"}, b_a, b_e);
        cmp({tag, " conflict"}, c_a, c_e);
        cmp({tag, " S&R"}, s_a & r_a, 1'b0);
    endtask

    initial begin
        // ---------------- vector table ----------------
        //     n  sel rst set clr   S  R  busy conf
        // Reset with both buttons held, then the held buttons act as a
        // simultaneous press: R+conflict at idx 6, gap, S, gap.
        add_n(2,  0,  1,  1,  1,   0, 0, 0, 0);
        add_n(6,  0,  0,  1,  1,   0, 0, 0, 0);
        add_n(1,  0,  0,  1,  1,   0, 1, 1, 1);
        add_n(1,  0,  0,  1,  1,   0, 0, 1, 0);
        add_n(1,  0,  0,  1,  1,   1, 0, 1, 0);
        add_n(1,  0,  0,  1,  1,   0, 0, 1, 0);
        add_n(2,  0,  0,  1,  1,   0, 0, 0, 0);
        add_n(8,  0,  0,  0,  0,   0, 0, 0, 0);
        // Clean set press held 20 cycles: one S pulse at idx 6 only.
        add_n(6,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(1,  0,  0,  1,  0,   1, 0, 1, 0);
        add_n(1,  0,  0,  1,  0,   0, 0, 1, 0);
        add_n(12, 0,  0,  1,  0,   0, 0, 0, 0);
        add_n(8,  0,  0,  0,  0,   0, 0, 0, 0);
        // Bounce 1,1,0,1 then low: nothing.
        add_n(2,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(1,  0,  0,  0,  0,   0, 0, 0, 0);
        add_n(1,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(10, 0,  0,  0,  0,   0, 0, 0, 0);
        // Bounce 1,0 then held 1: one S pulse 6 edges after the final rise.
        add_n(1,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(1,  0,  0,  0,  0,   0, 0, 0, 0);
        add_n(6,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(1,  0,  0,  1,  0,   1, 0, 1, 0);
        add_n(1,  0,  0,  1,  0,   0, 0, 1, 0);
        add_n(4,  0,  0,  1,  0,   0, 0, 0, 0);
        add_n(8,  0,  0,  0,  0,   0, 0, 0, 0);
        // PULSE_LEN=3: clear at idx 0, set at idx 2 lands during R -> pending.
        add_n(2,  1,  0,  0,  1,   0, 0, 0, 0);
        add_n(4,  1,  0,  1,  1,   0, 0, 0, 0);
        add_n(3,  1,  0,  1,  1,   0, 1, 1, 0);
        add_n(1,  1,  0,  1,  1,   0, 0, 1, 0);
        add_n(3,  1,  0,  1,  1,   1, 0, 1, 0);
        add_n(1,  1,  0,  1,  1,   0, 0, 1, 0);
        add_n(2,  1,  0,  1,  1,   0, 0, 0, 0);
        add_n(8,  1,  0,  0,  0,   0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].sel, tbl[i].rst, tbl[i].set, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].s, tbl[i].r,
                  tbl[i].busy, tbl[i].conf);
        end

        // ---------------- reset mid-pulse (PULSE_LEN=4) ----------------
        // Set held; a short clear press is debounced so its request is
        // pending during S. Reset in S's 2nd cycle must cut S and drop it.
        for (int k = 0; k < 8; k++) begin
            drive(2, 1'b0, 1'b1, (k >= 1 && k <= 5));
            check($sformatf("mid k%0d", k), 2, (k >= 6), 1'b0, (k >= 6), 1'b0);
        end
        drive(2, 1'b1, 1'b1, 1'b0);
        check("mid rst", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            drive(2, 1'b0, 1'b1, 1'b0);
            check($sformatf("post k%0d", k), 2, (k >= 6 && k <= 9), 1'b0,
                  (k >= 6 && k <= 10), 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(2, 1'b0, 1'b0, 1'b0);
            check($sformatf("rel k%0d", k), 2, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
